vpe_feature_feeder: RTL and testbench
=====================================

// Module: vpe_feature_feeder
// PURPOSE
//  Buffers per-packet 256-bit feature vectors from the parser and serves them to the VPE kernel.
//  A write-side valid/ready stream fills a circular FIFO. The kernel pulls one vector per
//  fetch_pkt_feature request. Each served vector is returned as a one-cycle pkt_feature_valid strobe.
//  Sits directly upstream of the VPE kernel top and drives its pkt_feature* inputs.
// PARAMETERS
//  DATA_W   256   feature vector width; must match kernel pkt_feature width
//  DEPTH    16    FIFO entries; power of two, >= 2
//  AW       4     log2(DEPTH); derived, not overridden
// PORTS
//  clk                clock; rising edge
//  rst                in   1       asynchronous, active-high reset
//  flush              in   1       synchronous clear of FIFO and pending request
//  in_valid           in   1       parser vector valid
//  in_data            in   DATA_W  parser feature vector
//  in_ready           out  1       FIFO can accept a vector this cycle
//  fetch_pkt_feature  in   1       kernel request for the next vector
//  pkt_feature_valid  out  1       one-cycle strobe; pkt_feature is valid
//  pkt_feature        out  DATA_W  served vector
//  occupancy          out  AW+1    entries stored, 0..DEPTH
//  served_cnt         out  32      vectors delivered since reset/flush; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (async, rst=1): all outputs are forced to 0, except in_ready=1.
//   - Pointers, occupancy, pending request, pkt_feature and served_cnt are cleared.
//   - FIFO storage is not cleared.
//   - Reset mid-transfer discards all stored vectors and any pending request.
//  Write path:
//   - in_ready = (occupancy != DEPTH), driven combinationally from registered state.
//   - A write occurs when in_valid & in_ready. The vector goes to wr_ptr; wr_ptr wraps modulo DEPTH.
//   - When full, no write occurs even if a pop happens in the same cycle.
//   - in_valid while full is not an error. The parser holds the vector.
//  Request FSM:
//   - States: IDLE, PEND.
//   - IDLE: fetch=1 and FIFO non-empty -> pop this cycle, stay in IDLE.
//   - IDLE: fetch=1 and FIFO empty -> go to PEND.
//   - PEND: FIFO non-empty -> pop, go to IDLE. fetch=1 while in PEND is absorbed (no second request).
//   - At most one outstanding request exists. Fetches are not queued.
//  Pop:
//   - Registered read of entry rd_ptr; rd_ptr wraps modulo DEPTH.
//   - The next cycle: pkt_feature <= entry and pkt_feature_valid=1 for exactly one cycle; served_cnt increments.
//   - pkt_feature holds its last value while valid=0.
//  Latency:
//   - fetch at cycle N with FIFO non-empty -> valid at N+1.
//   - Empty FIFO: a write at cycle M is visible at M+1. The pop happens at M+1 and valid is at M+2.
//   - No write-to-read bypass.
//  Occupancy:
//   - Write without pop: +1. Pop without write: -1. Simultaneous write and pop: unchanged.
//   - A pop never occurs when empty.
//  flush=1 has priority over write, pop and fetch in the same cycle:
//   - Pointers, occupancy, FSM (to IDLE) and served_cnt are cleared.
//   - pkt_feature_valid=0 next cycle.
// TESTING
//  T1: reset, fetch=1 for 1 cycle, then write 256'hA5 at cycle 5
//      -> FSM in PEND; pop at 6; pkt_feature_valid=1 with 256'hA5 at 7; served_cnt=1.
//  T2: write 0..15 back-to-back with no fetch
//      -> in_ready=0 after 16th write; occupancy=16; 17th vector held by parser until a fetch.
//  T3: full FIFO, in_valid=1 and fetch=1 in the same cycle
//      -> no write; occupancy=15; valid next cycle with vector 0.
//  T4: occupancy=3, in_valid=1 and fetch=1 each cycle for 20 cycles
//      -> occupancy stays 3; vectors come out in order; pointers wrap correctly.
//  T5: PEND state, flush=1 together with in_valid=1
//      -> occupancy=0, IDLE, no valid strobe; a later fetch with empty FIFO re-enters PEND.
//  T6: rst pulsed while occupancy=5 and a pop is in flight
//      -> valid=0 immediately; occupancy=0; in_ready=1; served_cnt=0.

Source files
------------

// File: rtl/vpe_feature_feeder_if.sv
// Handshake bundle between parser, feature feeder and VPE kernel.
// master: parser/kernel side; slave: feeder side.
interface vpe_feature_feeder_if #(
    parameter int unsigned DATA_W = 256
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              fetch_pkt_feature;
    logic              pkt_feature_valid;
    logic [DATA_W-1:0] pkt_feature;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        output fetch_pkt_feature,
        input  pkt_feature_valid,
        input  pkt_feature
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  fetch_pkt_feature,
        output pkt_feature_valid,
        output pkt_feature
    );
endinterface

// File: rtl/vpe_feature_feeder.sv
// Circular FIFO of parser feature vectors, served one per kernel fetch with a
// single outstanding request and a one-cycle valid strobe on the registered read.
module vpe_feature_feeder #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    vpe_feature_feeder_if.slave        feed_io,
    output logic [AW:0]                occupancy_o,
    output logic [31:0]                served_cnt_o
);

    localparam logic [AW:0]   OCC_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       occ_q, occ_d;
    logic [31:0]       served_q, served_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] feat_q, feat_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic wr_en;
    logic pop;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_FULL);
    // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign wr_en = feed_io.in_valid & ~full & ~flush_i;

    // Request FSM: decides when a pop happens.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (feed_io.fetch_pkt_feature) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            pop     = 1'b0;
        end
    end

    // Datapath next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        served_d = served_q;
        valid_d  = pop;
        feat_d   = feat_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            served_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                feat_d   = mem_q[rd_ptr_q];
                if (served_q != 32'hFFFF_FFFF) begin
                    served_d = served_q + 32'd1;
                end
            end
            unique case ({wr_en, pop})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            served_q <= '0;
            valid_q  <= 1'b0;
            feat_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            served_q <= served_d;
            valid_q  <= valid_d;
            feat_q   <= feat_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= feed_io.in_data;
        end
    end

    assign feed_io.in_ready          = ~full;
    assign feed_io.pkt_feature_valid = valid_q;
    assign feed_io.pkt_feature       = feat_q;
    assign occupancy_o               = occ_q;
    assign served_cnt_o              = served_q;

endmodule

// File: tb/tb_vpe_feature_feeder.sv
// Bench for vpe_feature_feeder: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_vpe_feature_feeder;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  occupancy;
    logic [31:0] served_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vpe_feature_feeder_if #(.DATA_W(DATA_W)) bus ();

    vpe_feature_feeder #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .feed_io     (bus.slave),
        .occupancy_o (occupancy),
        .served_cnt_o(served_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored vectors plus one outstanding-request flag.
    logic [DATA_W-1:0] mq [$];
    bit                m_pend;
    bit                m_valid;
    logic [DATA_W-1:0] m_feat;
    logic [31:0]       m_cnt;

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        fl;
        logic        ev;
        logic [7:0]  ef;
        logic [4:0]  eo;
        logic        er;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_feat  = '0;
        m_cnt   = '0;
    endtask

    task automatic model_step();
        int unsigned sz = mq.size();
        bit req;
        bit do_pop;
        bit do_wr;
        if (flush) begin
            mq.delete();
            m_pend  = 1'b0;
            m_cnt   = '0;
            m_valid = 1'b0;
            return;
        end
        req    = m_pend || bus.fetch_pkt_feature;
        do_pop = req && (sz > 0);
        do_wr  = bus.in_valid && (sz != DEPTH);
        m_valid = do_pop;
        if (do_pop) begin
            m_feat = mq.pop_front();
            m_pend = 1'b0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end else begin
            m_pend = req;
        end
        if (do_wr) mq.push_back(bus.in_data);
    endtask

    task automatic check_model(input string tag);
        int unsigned sz = mq.size();
        chk({tag, ".valid"}, DATA_W'(bus.pkt_feature_valid), DATA_W'(m_valid));
        chk({tag, ".feat"}, bus.pkt_feature, m_feat);
        chk({tag, ".occ"}, DATA_W'(occupancy), DATA_W'(sz));
        chk({tag, ".ready"}, DATA_W'(bus.in_ready), DATA_W'(sz != DEPTH));
        chk({tag, ".cnt"}, DATA_W'(served_cnt), DATA_W'(m_cnt));
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit fl);
        bus.in_valid          = v;
        bus.in_data           = d;
        bus.fetch_pkt_feature = f;
        flush                 = fl;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        //               v  d      f  fl  ev ef     eo  er  ec
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 32'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 32'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 32'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 32'd1};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 32'd1};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd2, 1'b1, 32'd1};
        tbl[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2, 1'b1, 32'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b1, 32'd3};
        tbl[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 32'd0};
        tbl[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h22, 5'd1, 1'b1, 32'd0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 5'd0, 1'b1, 32'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 5'd0, 1'b1, 32'd1};
        tbl[14] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h55, 5'd1, 1'b1, 32'd1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66, 5'd0, 1'b1, 32'd2};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h66, 5'd0, 1'b1, 32'd2};
        tbl[17] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h66, 5'd1, 1'b1, 32'd2};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h66, 5'd1, 1'b1, 32'd2};

        do_reset();

        // Vector table, starting straight from reset.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, DATA_W'(tbl[i].d), tbl[i].f, tbl[i].fl);
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid", i), DATA_W'(bus.pkt_feature_valid), DATA_W'(tbl[i].ev));
            chk($sformatf("tbl%0d.feat", i), bus.pkt_feature, DATA_W'(tbl[i].ef));
            chk($sformatf("tbl%0d.occ", i), DATA_W'(occupancy), DATA_W'(tbl[i].eo));
            chk($sformatf("tbl%0d.ready", i), DATA_W'(bus.in_ready), DATA_W'(tbl[i].er));
            chk($sformatf("tbl%0d.cnt", i), DATA_W'(served_cnt), DATA_W'(tbl[i].ec));
        end

        // Fill to full, hold the 17th vector, then full + write + fetch together.
        drive(1'b0, '0, 1'b0, 1'b1);
        cycle("t2_flush");
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
            cycle($sformatf("t2_wr%0d", i));
        end
        chk("t2_full_occ", DATA_W'(occupancy), DATA_W'(16));
        chk("t2_full_ready", DATA_W'(bus.in_ready), DATA_W'(0));
        drive(1'b1, DATA_W'(16), 1'b0, 1'b0);
        repeat (2) cycle("t2_hold");
        chk("t2_hold_occ", DATA_W'(occupancy), DATA_W'(16));
        drive(1'b1, DATA_W'(16), 1'b1, 1'b0);
        cycle("t3");
        chk("t3_occ", DATA_W'(occupancy), DATA_W'(15));
        chk("t3_valid", DATA_W'(bus.pkt_feature_valid), DATA_W'(1));
        chk("t3_feat", bus.pkt_feature, DATA_W'(0));
        drive(1'b1, DATA_W'(16), 1'b0, 1'b0);
        cycle("t3_refill");
        chk("t3_refill_occ", DATA_W'(occupancy), DATA_W'(16));

        // Steady stream at occupancy 3 with pointer wrap.
        drive(1'b0, '0, 1'b0, 1'b1);
        cycle("t4_flush");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DATA_W'(32'h100 + i), 1'b0, 1'b0);
            cycle("t4_pre");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DATA_W'(32'h200 + i), 1'b1, 1'b0);
            cycle($sformatf("t4_%0d", i));
            chk($sformatf("t4_occ%0d", i), DATA_W'(occupancy), DATA_W'(3));
        end
        chk("t4_last_feat", bus.pkt_feature, DATA_W'(32'h200 + 16));

        // Flush while pending, together with a write.
        drive(1'b0, '0, 1'b0, 1'b1);
        cycle("t5_clr");
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("t5_pend");
        drive(1'b1, DATA_W'(32'hBEEF), 1'b0, 1'b1);
        cycle("t5_flush");
        chk("t5_occ", DATA_W'(occupancy), DATA_W'(0));
        drive(1'b0, '0, 1'b0, 1'b0);
        cycle("t5_idle");
        chk("t5_novalid", DATA_W'(bus.pkt_feature_valid), DATA_W'(0));
        drive(1'b1, DATA_W'(32'hCAFE), 1'b0, 1'b0);
        cycle("t5_wr");
        drive(1'b0, '0, 1'b0, 1'b0);
        cycle("t5_still");
        chk("t5_nopop_occ", DATA_W'(occupancy), DATA_W'(1));
        drive(1'b0, '0, 1'b0, 1'b1);
        cycle("t5_clr2");
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("t5_pend2");
        drive(1'b1, DATA_W'(32'hD00D), 1'b0, 1'b0);
        cycle("t5_wr2");
        drive(1'b0, '0, 1'b0, 1'b0);
        cycle("t5_pop2");
        chk("t5_repend_valid", DATA_W'(bus.pkt_feature_valid), DATA_W'(1));

        // Async reset mid-cycle with occupancy 5 and a write presented.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DATA_W'(32'h300 + i), 1'b0, 1'b0);
            cycle("t6_fill");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("t6_pop");
        chk("t6_pre_occ", DATA_W'(occupancy), DATA_W'(5));
        drive(1'b1, DATA_W'(32'h399), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", DATA_W'(bus.pkt_feature_valid), DATA_W'(0));
        chk("t6_occ", DATA_W'(occupancy), DATA_W'(0));
        chk("t6_ready", DATA_W'(bus.in_ready), DATA_W'(1));
        chk("t6_cnt", DATA_W'(served_cnt), DATA_W'(0));
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6,
                  {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 63) == 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
